computer_system_led_pio_out: RTL

Avalon-MM slave output port that drives the board LEDs (or any output pins) from the processor, the output-direction companion of the pushbutton input port. Provides a data register with atomic set/clear, a hardware blink generator per bit, and a one-shot pulse engine so software can flash LEDs without polling timers. Sits on the system interconnect as a 3-bit-address slave with fixed one-cycle registered read latency.

---
 rtl/computer_system_led_pio_out.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/computer_system_led_pio_out.sv
// rtl/computer_system_led_pio_out.sv - Avalon-MM LED output port with set/clear, per-bit blink and one-shot pulse
module computer_system_led_pio_out #(
  parameter int WIDTH        = 10,
  parameter int PULSE_CYCLES = 5000000,
  parameter int BLINK_RESET  = 24999999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [25:0] BLINK_INIT = 26'(BLINK_RESET);
  localparam logic [31:0] PULSE_LOAD = 32'(PULSE_CYCLES - 1);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] blink_en;
  logic [25:0]      blink_period;
  logic [25:0]      blink_cnt;
  logic             phase;
  logic [WIDTH-1:0] pulse_mask;
  logic [31:0]      pulse_cnt;
  logic [31:0]      rd_mux;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             wr_data;
  logic             wr_blink_en;
  logic             wr_period;
  logic             wr_pulse;
  logic             wr_set;
  logic             wr_clr;
  logic             pulse_busy;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign wr_data      = wr_en && (address == 3'd0);
  assign wr_blink_en  = wr_en && (address == 3'd1);
  assign wr_period    = wr_en && (address == 3'd2);
  // A PULSE write whose in-range bits are all zero must not restart the counter
  assign wr_pulse     = wr_en && (address == 3'd3) && (wdata != '0);
  assign wr_set       = wr_en && (address == 3'd4);
  assign wr_clr       = wr_en && (address == 3'd5);
  assign pulse_busy   = (pulse_mask != '0);
  // Bits of writedata above the port width are intentionally dropped
  assign unused_wdata = ^writedata;

  // Base output value with direct write and atomic set/clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      blink_en <= '0;
    end else begin
      if (wr_data) begin
        data_reg <= wdata;
      end else if (wr_set) begin
        data_reg <= data_reg | wdata;
      end else if (wr_clr) begin
        data_reg <= data_reg & ~wdata;
      end
      if (wr_blink_en) begin
        blink_en <= wdata;
      end
    end
  end

  // Blink generator: period write restarts the half-period, period 0 parks phase low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_period <= BLINK_INIT;
      blink_cnt    <= BLINK_INIT;
      phase        <= 1'b0;
    end else if (wr_period) begin
      blink_period <= writedata[25:0];
      blink_cnt    <= writedata[25:0];
      phase        <= 1'b0;
    end else if (blink_period == '0) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt <= blink_period;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt - 26'd1;
    end
  end

  // One-shot pulse engine: a retrigger extends all pending bits and beats expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_mask <= '0;
      pulse_cnt  <= '0;
    end else if (wr_pulse) begin
      pulse_mask <= pulse_mask | wdata;
      pulse_cnt  <= PULSE_LOAD;
    end else if (pulse_busy) begin
      if (pulse_cnt == '0) begin
        pulse_mask <= '0;
      end else begin
        pulse_cnt <= pulse_cnt - 32'd1;
      end
    end
  end

  // LED drive is registered from current state, so writes show one edge later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= '0;
    end else begin
      out_port <= (data_reg ^ (blink_en & {WIDTH{phase}})) | pulse_mask;
    end
  end

  // Read select; reads are side-effect free and ignore chipselect
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = 32'(data_reg);
      3'd1:    rd_mux = 32'(blink_en);
      3'd2:    rd_mux = {6'd0, blink_period};
      3'd3:    rd_mux = 32'(pulse_mask);
      3'd4:    rd_mux = 32'(out_port);
      3'd6:    rd_mux = {30'd0, phase, pulse_busy};
      default: rd_mux = '0;
    endcase
  end

  // Fixed one-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
